fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined MIPS core: owns the PC, issues word requests to instruction memory over a req/ready handshake, and loads the IF/ID pipeline register whose instruction word feeds the ID-stage control decoder. It consumes the decoder's `IsBeq`, `IsBne`, `Jump` and `FullJump` outputs to redirect fetch, and squashes the wrong-path instruction. There is no branch delay slot; each redirect costs one bubble.

## Interface
- `RESET_PC`, 32'h0000_0000: PC after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `Stall` in 1: hazard unit; holds the PC and IF/ID.
- `IsBeq`, `IsBne`, `Jump`, `FullJump` in 1 each: decoder outputs for the instruction currently in IF/ID.
- `Equal` in 1: ID-stage compare result, rs == rt.
- `RegJumpAddr` in 32: rs value, the jr target.
- `IMemReq` out 1: fetch request.
- `IMemAddr` out 32: word address; held stable while `IMemReq` is high and `IMemReady` is low.
- `IMemReady` in 1: the response is valid this cycle; the transfer completes when `IMemReq` and `IMemReady` are both high.
- `IMemData` in 32: instruction word, sampled on completion.
- `IF_ID_Instr` out 32: IF/ID instruction.
- `IF_ID_PC4` out 32: IF/ID PC+4.
- `IF_ID_Valid` out 1: IF/ID holds a real instruction.

## Operation
**Redirect**
- Redirect condition: `redir = IF_ID_Valid & ~Stall & (FullJump | Jump | IsBeq&Equal | IsBne&~Equal)`.
- Target priority:
  - `FullJump`: `RegJumpAddr`.
  - else `Jump`: `{IF_ID_PC4[31:28], IF_ID_Instr[25:0], 2'b00}`.
  - else taken branch: `IF_ID_PC4 + (sext(IF_ID_Instr[15:0]) << 2)`, computed mod 2^32.

**FSM state**
- Registers: `PC`, `FetchAddr` (drives `IMemAddr`), `HoldBuf` (32 bit), and the state.
- RUN: `IMemReq=1`, `IMemAddr=FetchAddr`.
- HOLD: `IMemReq=0`. A completed word is buffered because ID is stalled.
- DROP: `IMemReq=1`, old `FetchAddr`. An in-flight request must finish, and its data is discarded.

**FSM transitions, evaluated each edge; reset overrides all**
- RUN, `redir`, completing: discard the data. `PC=FetchAddr=target`, stay RUN.
- RUN, `redir`, not completing: `PC=target`, go DROP.
- RUN, `~Stall`, completing: load IF/ID {`IMemData`, `FetchAddr+4`, 1}. `PC=FetchAddr=FetchAddr+4`.
- RUN, `Stall`, completing: `HoldBuf=IMemData`, go HOLD. IF/ID unchanged.
- RUN, not completing, `~Stall`: `IF_ID_Valid=0` (bubble).
- HOLD, `redir`: drop `HoldBuf`. `PC=FetchAddr=target`, go RUN.
- HOLD, `~Stall`: load IF/ID {`HoldBuf`, `FetchAddr+4`, 1}. `PC=FetchAddr=FetchAddr+4`, go RUN.
- HOLD, `Stall`: stay.
- DROP, completing: `FetchAddr=PC`, go RUN.
- DROP, otherwise: stay.

**IF/ID and redirect rules**
- On `redir`, IF/ID always loads `IF_ID_Valid=0`. `IF_ID_Instr` and `IF_ID_PC4` keep their values.
- While `Stall=1`, IF/ID holds all fields and `redir` is suppressed. The decoder reasserts the redirect after the stall releases.
- A second redirect cannot occur in DROP, because `IF_ID_Valid=0` there.
- Address bits [1:0] are passed through unchecked; alignment is the software's responsibility.

## Timing
- Reset values:
  - `IMemReq=0`, `IF_ID_Valid=0`, `IF_ID_Instr=0`, `IF_ID_PC4=0`.
  - `PC=FetchAddr=RESET_PC`, state RUN.
- First request: first cycle after `reset` falls, with `IMemAddr=RESET_PC`.
- Zero-wait memory (`IMemReady` tied high): one instruction per cycle into IF/ID. The word at address A appears in IF/ID in the cycle after A is presented.
- Redirect penalty:
  - Zero-wait memory: exactly one invalid IF/ID cycle. The target word is requested in the cycle after `redir` and is valid in IF/ID one cycle later.
  - Otherwise, plus any DROP wait cycles.
- Reset mid-request: the outstanding transfer is abandoned. Instruction memory shares `reset` and aborts it too.
- Simultaneous `Stall` and completion in RUN: the data is captured in `HoldBuf` and never lost or refetched.

## Test plan
- **Reset, straight-line fetch.** `RESET_PC=0`, ready high, no control inputs.
  - `IMemAddr` goes 0, 4, 8, ….
  - `IF_ID_PC4` goes 4, 8, … with `IF_ID_Valid=1` from the 2nd cycle after reset.
  - `IMemReq=0` during reset.
- **Taken branch.**
  - beq at 0x10 with imm=0x0003 and `Equal=1` → next request 0x20, with one `IF_ID_Valid=0` cycle.
  - The same with `Equal=0` → sequential fetch, no bubble.
  - bne with imm=0xFFFF, `Equal=0`, at 0x10 → target 0x10.
- **Jump priority.**
  - `Jump=1` with instr[25:0]=0x0000040 and `IF_ID_PC4=0x0000_0008` → 0x0000_0100.
  - `FullJump=1` with `RegJumpAddr=0x0000_3000` and `IsBeq&Equal` also high → 0x0000_3000.
- **Stall capture.**
  - `Stall` high in the same cycle a word completes → `IMemReq=0` next cycle, IF/ID frozen.
  - On release, that word loads into IF/ID and fetch resumes at +4 with no duplicate request.
- **Redirect during a wait.**
  - `IMemReady` low for 3 cycles while a jump to 0x40 resolves → `IMemAddr` stays at the old address until ready.
  - The returned word is discarded (never valid in IF/ID), then a request to 0x40 is issued.
- **Mid-stream reset.** Assert `reset` for one cycle during DROP → state RUN, `IMemAddr=RESET_PC` after release, all IF/ID outputs 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the pipelined MIPS core. Owns the PC, fetches
// words over a req/ready handshake and fills IF/ID, redirecting on jumps and taken branches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        IsBeq,
  input  logic        IsBne,
  input  logic        Jump,
  input  logic        FullJump,
  input  logic        Equal,
  input  logic [31:0] RegJumpAddr,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid
);

  typedef enum logic [1:0] {RUN, HOLD, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] fetch_addr, fetch_addr_nxt;
  logic [31:0] hold_buf, hold_buf_nxt;
  logic [31:0] instr_nxt, pc4_nxt;
  logic        valid_nxt;
  logic        taken, redir, complete;
  logic [31:0] target, branch_off, seq_addr;

  // The request is masked during reset so memory never sees a fetch before reset falls.
  assign IMemReq    = ~reset & (state != HOLD);
  assign IMemAddr   = fetch_addr;
  assign complete   = IMemReq & IMemReady;
  assign taken      = FullJump | Jump | (IsBeq & Equal) | (IsBne & ~Equal);
  assign redir      = IF_ID_Valid & ~Stall & taken;
  assign branch_off = {{14{IF_ID_Instr[15]}}, IF_ID_Instr[15:0], 2'b00};
  assign seq_addr   = fetch_addr + 32'd4;

  always_comb begin
    target = IF_ID_PC4 + branch_off;
    if (FullJump)
      target = RegJumpAddr;
    else if (Jump)
      target = {IF_ID_PC4[31:28], IF_ID_Instr[25:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      fetch_addr  <= RESET_PC;
      hold_buf    <= '0;
      IF_ID_Instr <= '0;
      IF_ID_PC4   <= '0;
      IF_ID_Valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetch_addr  <= fetch_addr_nxt;
      hold_buf    <= hold_buf_nxt;
      IF_ID_Instr <= instr_nxt;
      IF_ID_PC4   <= pc4_nxt;
      IF_ID_Valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    fetch_addr_nxt = fetch_addr;
    hold_buf_nxt   = hold_buf;
    instr_nxt      = IF_ID_Instr;
    pc4_nxt        = IF_ID_PC4;
    valid_nxt      = IF_ID_Valid;

    // A redirect squashes IF/ID; the wrong-path word is never loaded.
    if (redir)
      valid_nxt = 1'b0;

    case (state)
      RUN: begin
        if (redir) begin
          pc_nxt = target;
          if (complete)
            fetch_addr_nxt = target;
          else
            state_nxt = DROP;
        end else if (complete && !Stall) begin
          instr_nxt      = IMemData;
          pc4_nxt        = seq_addr;
          valid_nxt      = 1'b1;
          pc_nxt         = seq_addr;
          fetch_addr_nxt = seq_addr;
        end else if (complete) begin
          hold_buf_nxt = IMemData;
          state_nxt    = HOLD;
        end else if (!Stall) begin
          valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_nxt         = target;
          fetch_addr_nxt = target;
          state_nxt      = RUN;
        end else if (!Stall) begin
          instr_nxt      = hold_buf;
          pc4_nxt        = seq_addr;
          valid_nxt      = 1'b1;
          pc_nxt         = seq_addr;
          fetch_addr_nxt = seq_addr;
          state_nxt      = RUN;
        end
      end
      DROP: begin
        // The in-flight word is thrown away; fetch restarts at the redirect target held in pc.
        if (complete) begin
          fetch_addr_nxt = pc;
          state_nxt      = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit with a small program memory and acts as the ID-stage
// decoder; an architectural trace of expected IF/ID entries is compared as they appear.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Stall = 1'b0;
  logic        IsBeq, IsBne, Jump, FullJump;
  logic        Equal = 1'b0;
  logic [31:0] RegJumpAddr = 32'h0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady = 1'b1;
  logic [31:0] IMemData;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_Valid;

  logic [31:0] prog [0:63];
  logic        beq_with_jr = 1'b0;
  logic        sb_on = 1'b1;
  entry_t      sbq [$];

  int          checks = 0;
  int          errors = 0;
  int          ti = 0;
  int          bubbles = 0;
  int          exp_bub = 0;
  int          watch_hits = 0;
  logic        seen_first = 1'b0;
  logic [31:0] watch_addr = 32'hFFFF_FFF0;

  logic [31:0] addr_log  [0:63];
  logic [31:0] pc4_log   [0:63];
  logic [31:0] instr_log [0:63];
  logic        req_log   [0:63];
  logic        valid_log [0:63];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .Stall(Stall),
    .IsBeq(IsBeq), .IsBne(IsBne), .Jump(Jump), .FullJump(FullJump),
    .Equal(Equal), .RegJumpAddr(RegJumpAddr),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady), .IMemData(IMemData),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC4(IF_ID_PC4), .IF_ID_Valid(IF_ID_Valid)
  );

  always #5 clk = ~clk;

  // Memory returns the program image in the low 256 bytes and an address-tagged addi elsewhere.
  always_comb
    IMemData = (IMemAddr[31:8] == 24'h0) ? prog[IMemAddr[7:2]] : {6'h08, 10'h0, IMemAddr[15:0]};

  logic [5:0] dec_op;
  logic       dec_jr;
  assign dec_op   = IF_ID_Instr[31:26];
  assign dec_jr   = (dec_op == 6'h00) && (IF_ID_Instr[5:0] == 6'h08);
  assign FullJump = dec_jr;
  assign Jump     = (dec_op == 6'h02);
  assign IsBeq    = (dec_op == 6'h04) || (dec_jr && beq_with_jr);
  assign IsBne    = (dec_op == 6'h05);

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a[31:8] == 24'h0) ? prog[a[7:2]] : {6'h08, 10'h0, a[15:0]};
  endfunction

  function automatic logic [31:0] archNext(input logic [31:0] pc4, input logic [31:0] instr,
                                           output logic tk);
    logic [5:0] op;
    op = instr[31:26];
    tk = 1'b1;
    if (op == 6'h00 && instr[5:0] == 6'h08) return RegJumpAddr;
    if (op == 6'h02) return {pc4[31:28], instr[25:0], 2'b00};
    if ((op == 6'h04 && Equal) || (op == 6'h05 && !Equal))
      return pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    tk = 1'b0;
    return pc4;
  endfunction

  // Pushes k expected IF/ID entries; returns the redirect count between the first and last.
  function automatic int buildTrace(input int k);
    logic [31:0] pc, instr, nxt;
    logic        tk;
    entry_t      e;
    int          redirects;
    redirects = 0;
    pc = 32'h0;
    for (int i = 0; i < k; i++) begin
      instr   = memWord(pc);
      e.pc4   = pc + 32'd4;
      e.instr = instr;
      sbq.push_back(e);
      nxt = archNext(e.pc4, instr, tk);
      if (tk && i < k - 1) redirects++;
      pc = nxt;
    end
    return redirects;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    entry_t e;
    #1;
    if (ti < 64) begin
      addr_log[ti]  = IMemAddr;
      pc4_log[ti]   = IF_ID_PC4;
      instr_log[ti] = IF_ID_Instr;
      req_log[ti]   = IMemReq;
      valid_log[ti] = IF_ID_Valid;
    end
    if (IMemReq === 1'b1 && IMemReady && IMemAddr === watch_addr) watch_hits++;
    if (sb_on && !reset) begin
      if (IF_ID_Valid === 1'b1 && !Stall && sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("sb_pc4", IF_ID_PC4, e.pc4);
        checkOutput("sb_instr", IF_ID_Instr, e.instr);
        seen_first = 1'b1;
      end else if (IF_ID_Valid !== 1'b1 && seen_first && sbq.size() > 0) begin
        bubbles++;
      end
    end
    ti++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clearProg();
    for (int i = 0; i < 64; i++) prog[i] = {6'h08, 10'h0, 16'(i * 4)};
  endtask

  task automatic resetDut();
    reset = 1'b1; Stall = 1'b0; IMemReady = 1'b1; Equal = 1'b0; beq_with_jr = 1'b0;
    stepCycle();
    #1;
    checkOutput("rst_req", {31'b0, IMemReq}, 32'd0);
    checkOutput("rst_valid", {31'b0, IF_ID_Valid}, 32'd0);
    checkOutput("rst_pc4", IF_ID_PC4, 32'h0);
    checkOutput("rst_instr", IF_ID_Instr, 32'h0);
    checkOutput("rst_addr", IMemAddr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    ti = 0; bubbles = 0; seen_first = 1'b0; watch_hits = 0; watch_addr = 32'hFFFF_FFF0;
    sbq.delete();
  endtask

  task automatic applyStimulus(input int stall_at, input int stall_len,
                               input int nrdy_at, input int nrdy_len);
    for (int t = 0; t < 60 && sbq.size() > 0; t++) begin
      Stall     = (t >= stall_at) && (t < stall_at + stall_len);
      IMemReady = !((t >= nrdy_at) && (t < nrdy_at + nrdy_len));
      stepCycle();
    end
    checkOutput("drain", sbq.size(), 32'd0);
    checkOutput("bubbles", bubbles, exp_bub);
    Stall = 1'b0;
    IMemReady = 1'b1;
  endtask

  initial begin
    @(negedge clk);

    clearProg(); resetDut();
    exp_bub = buildTrace(6);
    applyStimulus(-1, 0, -1, 0);
    for (int k = 0; k < 4; k++) checkOutput("seq_addr", addr_log[k], 32'(k * 4));
    checkOutput("seq_first_req", {31'b0, req_log[0]}, 32'd1);
    checkOutput("seq_valid0", {31'b0, valid_log[0]}, 32'd0);
    checkOutput("seq_valid1", {31'b0, valid_log[1]}, 32'd1);
    checkOutput("seq_pc4_1", pc4_log[1], 32'h4);

    clearProg(); prog[4] = 32'h1022_0003; resetDut(); Equal = 1'b1;
    exp_bub = buildTrace(8);
    applyStimulus(-1, 0, -1, 0);
    checkOutput("beq_target", addr_log[6], 32'h20);
    checkOutput("beq_bubble", {31'b0, valid_log[6]}, 32'd0);

    clearProg(); prog[4] = 32'h1022_0003; resetDut(); Equal = 1'b0;
    exp_bub = buildTrace(8);
    applyStimulus(-1, 0, -1, 0);
    checkOutput("beq_nt_addr", addr_log[6], 32'h18);

    clearProg(); prog[4] = 32'h1422_FFFF; resetDut(); Equal = 1'b0;
    exp_bub = buildTrace(8);
    applyStimulus(-1, 0, -1, 0);
    checkOutput("bne_target", addr_log[6], 32'h10);

    clearProg(); prog[1] = 32'h0800_0040; resetDut();
    exp_bub = buildTrace(5);
    applyStimulus(-1, 0, -1, 0);
    checkOutput("j_target", addr_log[3], 32'h100);

    clearProg(); prog[2] = 32'h0020_0008; resetDut();
    Equal = 1'b1; beq_with_jr = 1'b1; RegJumpAddr = 32'h0000_3000;
    exp_bub = buildTrace(5);
    applyStimulus(-1, 0, -1, 0);
    checkOutput("jr_target", addr_log[4], 32'h3000);
    beq_with_jr = 1'b0;

    clearProg(); resetDut(); watch_addr = 32'hC;
    exp_bub = buildTrace(6);
    applyStimulus(3, 2, -1, 0);
    checkOutput("stall_req_off", {31'b0, req_log[4]}, 32'd0);
    checkOutput("stall_frozen", pc4_log[4], 32'hC);
    checkOutput("stall_req_off2", {31'b0, req_log[5]}, 32'd0);
    checkOutput("stall_resume", addr_log[6], 32'h10);
    checkOutput("stall_resume_req", {31'b0, req_log[6]}, 32'd1);
    checkOutput("stall_no_dup", watch_hits, 32'd1);

    clearProg(); prog[1] = 32'h0800_0010; resetDut(); watch_addr = 32'h8;
    exp_bub = 4;
    void'(buildTrace(5));
    applyStimulus(-1, 0, 2, 3);
    for (int k = 2; k < 6; k++) checkOutput("drop_hold_addr", addr_log[k], 32'h8);
    checkOutput("drop_req", {31'b0, req_log[3]}, 32'd1);
    checkOutput("drop_target", addr_log[6], 32'h40);
    checkOutput("drop_invalid3", {31'b0, valid_log[3]}, 32'd0);
    checkOutput("drop_invalid6", {31'b0, valid_log[6]}, 32'd0);
    checkOutput("drop_one_xfer", watch_hits, 32'd1);

    clearProg(); prog[1] = 32'h0800_0010; resetDut(); sb_on = 1'b0;
    for (int t = 0; t < 7; t++) begin
      IMemReady = !(t >= 2 && t < 4);
      reset     = (t == 3);
      stepCycle();
    end
    reset = 1'b0; IMemReady = 1'b1; sb_on = 1'b1;
    checkOutput("mrst_req_low", {31'b0, req_log[3]}, 32'd0);
    checkOutput("mrst_addr", addr_log[4], 32'h0);
    checkOutput("mrst_req", {31'b0, req_log[4]}, 32'd1);
    checkOutput("mrst_valid", {31'b0, valid_log[4]}, 32'd0);
    checkOutput("mrst_pc4", pc4_log[4], 32'h0);
    checkOutput("mrst_instr", instr_log[4], 32'h0);
    checkOutput("mrst_refetch_pc4", pc4_log[5], 32'h4);
    checkOutput("mrst_refetch_valid", {31'b0, valid_log[5]}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
